matmul_array: RTL

- Parametrised weight-broadcast matrix-multiply array. LANES parallel MAC lanes share one weight per beat.
- Each lane accumulates K_DEPTH products into an ACCW-bit dot product. The completed result vector is moved into a separate output register and offered on a valid/ready port.
- Because results sit in their own register, accumulation of the next tile overlaps the draining of the previous one.
- Sits between the activation/weight streamers and the result writeback path.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/matmul_if.sv | 18 +
 rtl/matmul_lane.sv | 37 +++
 rtl/matmul_array.sv | 51 +++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared defaults, counter width and lane slice helpers for matmul_array.
package matmul_pkg;
  localparam int LANES_D = 16;
  localparam int DW_D = 8;
  localparam int ACCW_D = 32;
  localparam int K_DEPTH_D = 16;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  function automatic int kw(int k_depth);
    return $clog2(k_depth) + 1;
  endfunction
  function automatic int lo(int lane, int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/matmul_if.sv
// matmul_if: input beat stream and result port of matmul_array.
interface matmul_if import matmul_pkg::*; #(
  parameter int LANES = LANES_D,
  parameter int DW = DW_D,
  parameter int ACCW = ACCW_D,
  parameter int K_DEPTH = K_DEPTH_D
);
  logic valid_i;
  logic in_rdy_o;
  logic [LANES*DW-1:0] din_i;
  logic [DW-1:0] win_i;
  logic vld_o;
  logic rdy_i;
  logic [LANES*ACCW-1:0] matmul_o;
  logic [kw(K_DEPTH)-1:0] k_cnt_o;
  modport master (output valid_i, din_i, win_i, rdy_i, input in_rdy_o, vld_o, matmul_o, k_cnt_o);
  modport slave (input valid_i, din_i, win_i, rdy_i, output in_rdy_o, vld_o, matmul_o, k_cnt_o);
endinterface

// File: rtl/matmul_lane.sv
// matmul_lane: one MAC lane; the accumulator restarts after the last beat of a tile.
// MATMUL_SAT_EN selects a saturating accumulate instead of wrap-around.
module matmul_lane #(
  parameter int DW = 8,
  parameter int ACCW = 32,
  parameter bit SIGNED = 0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            acc_en,
  input  logic            last,
  input  logic            clear,
  input  logic [DW-1:0]   din,
  input  logic [DW-1:0]   win,
  output logic [ACCW-1:0] sum
);
  logic [ACCW-1:0] a, b, prod, acc;
  assign a = {{(ACCW-DW){SIGNED && din[DW-1]}}, din};
  assign b = {{(ACCW-DW){SIGNED && win[DW-1]}}, win};
  assign prod = a * b;
`ifdef MATMUL_SAT_EN
  logic [ACCW:0] raw;
  logic ovf;
  // signed overflow: operands agree in sign but the sum does not
  always_comb begin
    raw = {1'b0, acc} + {1'b0, prod};
    ovf = SIGNED ? (acc[ACCW-1] == prod[ACCW-1]) && (raw[ACCW-1] != acc[ACCW-1]) : raw[ACCW];
    sum = !ovf ? raw[ACCW-1:0] : SIGNED ? {acc[ACCW-1], {(ACCW-1){!acc[ACCW-1]}}} : '1;
  end
`else
  assign sum = acc + prod;
`endif
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) acc <= '0;
    else if (clear || (acc_en && last)) acc <= '0;
    else if (acc_en) acc <= sum;
endmodule

// File: rtl/matmul_array.sv
// matmul_array: weight-broadcast MAC array with a separate result register so draining overlaps accumulation.
// Define MATMUL_SAT_EN for saturating accumulation.
module matmul_array import matmul_pkg::*; #(
  parameter int LANES = LANES_D,
  parameter int DW = DW_D,
  parameter int ACCW = ACCW_D,
  parameter int K_DEPTH = K_DEPTH_D,
  parameter bit SIGNED = 0
) (
  input logic     clk_i,
  input logic     rstn_i,
  input logic     en_i,
  input logic     clear_i,
  matmul_if.slave bus
);
  localparam int KW = kw(K_DEPTH);
  logic [KW-1:0] k;
  logic [0:0] state;
  logic [LANES*ACCW-1:0] sum, out;
  logic last, acc_en, load;
  assign last = k == KW'(K_DEPTH - 1);
  // only a last beat can stall: it needs the result register free
  assign bus.in_rdy_o = !(last && state == FULL && !bus.rdy_i);
  assign acc_en = en_i && bus.valid_i && bus.in_rdy_o;
  assign load = acc_en && last && !clear_i;
  assign bus.vld_o = state == FULL;
  assign bus.matmul_o = out;
  assign bus.k_cnt_o = k;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      k <= '0;
      state <= EMPTY;
      out <= '0;
    end else begin
      k <= (clear_i || load) ? '0 : acc_en ? k + 1'b1 : k;
      state <= load ? FULL : bus.rdy_i ? EMPTY : state;
      if (load) out <= sum;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    matmul_lane #(.DW(DW), .ACCW(ACCW), .SIGNED(SIGNED)) u_lane (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .acc_en (acc_en),
      .last   (last),
      .clear  (clear_i),
      .din    (bus.din_i[lo(i, DW) +: DW]),
      .win    (bus.win_i),
      .sum    (sum[lo(i, ACCW) +: ACCW])
    );
  end
endmodule
